// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one bit per clock, LSB first
//
// Ports:
//   clk    - clock, rising edge active
//   rst_n  - asynchronous active-low reset
//   start  - begin an operation (accepted in IDLE or DONE, ignored while busy)
//   a, b   - operands, captured at start
//   sub    - 0: a+b, 1: a-b (computed as a + ~b + 1)
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when a result is loaded
//   sum    - result, held until the next completion
//   cout   - carry out of the MSB (for subtract: 1 means no borrow)
//   ovf    - two's-complement signed overflow
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Single full-adder cell working on the operand LSBs.
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    assign bit_s    = a_reg[0] ^ b_reg[0] ^ carry;
    assign bit_c    = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign res_next = {bit_s, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        // The carry flop holding sub supplies the +1 of a + ~b + 1.
                        b_reg <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    res_reg <= res_next;
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= bit_c;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // On the MSB step, carry holds the carry into the MSB.
                        sum   <= res_next;
                        cout  <= bit_c;
                        ovf   <= carry ^ bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
